// File: rtl/ex_div_seq_if.sv
// Handshake/operand bundle between the EX stage and the iterative divider.
// master = EX stage side, slave = divider side.
interface ex_div_seq_if #(
  parameter int XLEN = 32
);
  logic            start;
  logic            signed_op;
  logic            want_rem;
  logic [XLEN-1:0] dividend;
  logic [XLEN-1:0] divisor;
  logic            annul;
  logic            stall_req;
  logic            ready;
  logic [XLEN-1:0] result;
  logic            busy;

  modport master (
    output start, signed_op, want_rem, dividend, divisor, annul,
    input  stall_req, ready, result, busy
  );

  modport slave (
    input  start, signed_op, want_rem, dividend, divisor, annul,
    output stall_req, ready, result, busy
  );
endinterface

// File: rtl/ex_div_seq.sv
// Radix-2 restoring divider for DIV/DIVU/REM/REMU, one quotient bit per clock.
// Divides magnitudes and fixes signs at the end; divide-by-zero and signed
// overflow resolve in one cycle.
// Optional: define DIV_EARLY_OUT_EN to finish in one cycle when
// |divisor| > |dividend| (quotient 0, remainder = dividend).
// CNT_W must satisfy 2**CNT_W > XLEN.
module ex_div_seq #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 6
) (
  input logic          clk,
  input logic          rst,
  ex_div_seq_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  state_t            state, state_nx;
  logic [CNT_W-1:0]  cnt;
  logic [XLEN-1:0]   rem, quo, dvs, result_q;
  logic              neg_q, neg_r, want_rem_q;

  logic [XLEN-1:0]   abs_a, abs_b, special_res, rem_nx, quo_nx, final_res;
  logic [XLEN:0]     rem_sh, trial;
  logic              div_zero, ovf, early, short_path, last, accept;

  // Operand magnitudes and one-cycle outcomes, evaluated at acceptance.
  assign abs_a    = (bus.signed_op && bus.dividend[XLEN-1]) ? -bus.dividend : bus.dividend;
  assign abs_b    = (bus.signed_op && bus.divisor[XLEN-1])  ? -bus.divisor  : bus.divisor;
  assign div_zero = (bus.divisor == '0);
  assign ovf      = bus.signed_op && (bus.dividend == MIN_NEG) && (bus.divisor == '1);
`ifdef DIV_EARLY_OUT_EN
  assign early    = !div_zero && !ovf && (abs_b > abs_a);
`else
  assign early    = 1'b0;
`endif
  assign short_path = div_zero || ovf || early;
  assign special_res = div_zero ? (bus.want_rem ? bus.dividend : '1) :
                       ovf      ? (bus.want_rem ? '0 : bus.dividend) :
                                  (bus.want_rem ? bus.dividend : '0);

  // One restoring step: shift {rem,quo}, trial subtract, keep if non-negative.
  assign rem_sh    = {rem, quo[XLEN-1]};
  assign trial     = rem_sh - {1'b0, dvs};
  assign rem_nx    = trial[XLEN] ? rem_sh[XLEN-1:0] : trial[XLEN-1:0];
  assign quo_nx    = {quo[XLEN-2:0], ~trial[XLEN]};
  assign last      = (cnt == CNT_W'(XLEN-1));
  assign final_res = want_rem_q ? (neg_r ? -rem_nx : rem_nx)
                                : (neg_q ? -quo_nx : quo_nx);

  assign accept        = (state == IDLE) && bus.start && !bus.annul;
  assign bus.stall_req = accept || (state == RUN);
  assign bus.ready     = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_q;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next state: annul wins everywhere; DONE always drops back to IDLE.
  always_comb begin
    state_nx = state;
    if (bus.annul) begin
      state_nx = IDLE;
    end else begin
      unique case (state)
        IDLE:    if (bus.start) state_nx = short_path ? DONE : RUN;
        RUN:     if (last)      state_nx = DONE;
        DONE:                   state_nx = IDLE;
        default:                state_nx = IDLE;
      endcase
    end
  end

  // Datapath: latch operands at acceptance, iterate in RUN, hold result otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt        <= '0;
      rem        <= '0;
      quo        <= '0;
      dvs        <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      want_rem_q <= 1'b0;
      result_q   <= '0;
    end else if (!bus.annul) begin
      if (accept) begin
        cnt        <= '0;
        rem        <= '0;
        quo        <= abs_a;
        dvs        <= abs_b;
        neg_q      <= bus.signed_op & (bus.dividend[XLEN-1] ^ bus.divisor[XLEN-1]);
        neg_r      <= bus.signed_op & bus.dividend[XLEN-1];
        want_rem_q <= bus.want_rem;
        if (short_path) result_q <= special_res;
      end else if (state == RUN) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + CNT_W'(1);
        if (last) result_q <= final_res;
      end
    end
  end

endmodule

// File: tb/tb_ex_div_seq.sv
// Directed bench for ex_div_seq: driver pushes expected results into a
// scoreboard queue, a negedge monitor pops and compares on each ready pulse.
module tb_ex_div_seq;
  localparam int XLEN = 32;
`ifdef DIV_EARLY_OUT_EN
  localparam int EO_STALL = 1;
`else
  localparam int EO_STALL = 33;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_div_seq_if #(.XLEN(XLEN)) bus();
  ex_div_seq #(.XLEN(XLEN), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] exp_q[$];
  string           name_q[$];
  logic [XLEN-1:0] last_res = '0;
  logic            prev_ready = 1'b0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Monitor: every ready pulse must match the oldest pending expectation.
  always @(negedge clk) begin
    if (!rst && bus.ready) begin
      check("ready_single_cycle", {31'b0, prev_ready}, 32'd0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready: got result %h expected no ready", bus.result);
      end else begin
        check(name_q.pop_front(), bus.result, exp_q.pop_front());
      end
    end
    prev_ready <= bus.ready;
  end

  // Issue one op, hold it until ready, and check how long stall_req was high.
  task automatic run_op(input string nm, input logic s, input logic r,
                        input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                        input logic [XLEN-1:0] exp, input int exp_stall);
    int stalls = 0;
    int cyc = 0;
    exp_q.push_back(exp);
    name_q.push_back(nm);
    bus.start = 1'b1; bus.signed_op = s; bus.want_rem = r;
    bus.dividend = a; bus.divisor = b;
    forever begin
      #1;
      if (bus.stall_req) stalls++;
      if (bus.ready && cyc > 0) break;
      if (cyc > 100) begin
        check({nm, "_timeout"}, 32'(cyc), 32'd0);
        break;
      end
      cyc++;
      @(negedge clk);
    end
    bus.start = 1'b0;
    check({nm, "_stall"}, 32'(stalls), 32'(exp_stall));
    last_res = exp;
  endtask

  initial begin
    bus.start = 1'b0; bus.signed_op = 1'b0; bus.want_rem = 1'b0;
    bus.dividend = '0; bus.divisor = '0; bus.annul = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_result", bus.result, 32'd0);
    check("rst_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_busy", {31'b0, bus.busy}, 32'd0);
    check("rst_stall", {31'b0, bus.stall_req}, 32'd0);

    run_op("divu_100_7", 1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33);
    run_op("remu_100_7", 1'b0, 1'b1, 32'd100, 32'd7, 32'd2, 33);
    run_op("div_m7_2",   1'b1, 1'b0, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 33);
    run_op("rem_m7_2",   1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 33);
    run_op("rem_7_m2",   1'b1, 1'b1, 32'd7, 32'hFFFF_FFFE, 32'd1, 33);
    run_op("div_20_m3",  1'b1, 1'b0, 32'd20, 32'hFFFF_FFFD, 32'hFFFF_FFFA, 33);
    run_op("divu_5_0",   1'b0, 1'b0, 32'd5, 32'd0, 32'hFFFF_FFFF, 1);
    run_op("remu_5_0",   1'b0, 1'b1, 32'd5, 32'd0, 32'd5, 1);
    run_op("rem_m5_0",   1'b1, 1'b1, 32'hFFFF_FFFB, 32'd0, 32'hFFFF_FFFB, 1);
    run_op("div_ovf",    1'b1, 1'b0, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1);
    run_op("rem_ovf",    1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 1);
    run_op("divu_5_9",   1'b0, 1'b0, 32'd5, 32'd9, 32'd0, EO_STALL);
    run_op("remu_5_9",   1'b0, 1'b1, 32'd5, 32'd9, 32'd5, EO_STALL);
    // Back-to-back: second op is presented during DONE and must wait for IDLE.
    run_op("b2b_100_7",  1'b0, 1'b0, 32'd100, 32'd7, 32'd14, 33);
    run_op("b2b_81_9",   1'b0, 1'b0, 32'd81, 32'd9, 32'd9, 33);

    // Annul mid-RUN at counter 10.
    @(negedge clk); #1;
    bus.start = 1'b1; bus.signed_op = 1'b0; bus.want_rem = 1'b0;
    bus.dividend = 32'd100; bus.divisor = 32'd7;
    repeat (11) @(posedge clk);
    #1 bus.annul = 1'b1;
    check("annul_busy_before", {31'b0, bus.busy}, 32'd1);
    @(posedge clk);
    #1 bus.annul = 1'b0; bus.start = 1'b0;
    check("annul_busy_after", {31'b0, bus.busy}, 32'd0);
    check("annul_ready", {31'b0, bus.ready}, 32'd0);
    check("annul_result_held", bus.result, last_res);
    repeat (3) @(negedge clk);
    #1;
    run_op("divu_9_3", 1'b0, 1'b0, 32'd9, 32'd3, 32'd3, 33);

    // Annul in IDLE blocks acceptance.
    @(negedge clk); #1;
    bus.start = 1'b1; bus.annul = 1'b1; bus.dividend = 32'd9; bus.divisor = 32'd3;
    #1 check("annul_idle_stall", {31'b0, bus.stall_req}, 32'd0);
    @(posedge clk);
    #1 check("annul_idle_busy", {31'b0, bus.busy}, 32'd0);
    bus.start = 1'b0; bus.annul = 1'b0;

    // Reset mid-RUN.
    @(negedge clk); #1;
    bus.start = 1'b1; bus.dividend = 32'd100; bus.divisor = 32'd7;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1; bus.start = 1'b0;
    @(posedge clk);
    #1;
    check("rst_run_result", bus.result, 32'd0);
    check("rst_run_ready", {31'b0, bus.ready}, 32'd0);
    check("rst_run_busy", {31'b0, bus.busy}, 32'd0);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("pending_results", 32'(exp_q.size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end
endmodule
